// File: rtl/wb_sram_responder.sv
// Wishbone classic single-port word SRAM responder with byte lanes and programmable wait states.
// Optional out-of-range error response is enabled by defining WB_SRAM_RESPONDER_ERR_EN.
module wb_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] bus__adr,
    input  logic [31:0] bus__dat_w,
    output logic [31:0] bus__dat_r,
    input  logic [3:0]  bus__sel,
    input  logic        bus__cyc,
    input  logic        bus__stb,
    input  logic        bus__we,
    output logic        bus__ack,
    output logic        bus__err
);

    localparam int          IW      = $clog2(DEPTH);
    localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  WS_W    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_r_q, dat_r_d;

    logic [29:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_w_q, dat_w_d;

    logic [31:0] mem_q [DEPTH];

    logic          req;
    logic [29:0]   eff_adr;
    logic          eff_we;
    logic [3:0]    eff_sel;
    logic [31:0]   eff_dat_w;
    logic [29:0]   off;
    logic [IW-1:0] idx;
    logic          oor;
    logic          enter_resp;
    logic          mem_we;
    logic          unused_off;

    // The request is consumed straight off the bus when RESP follows IDLE directly,
    // otherwise from the copy latched at accept time.
    always_comb begin
        req = bus__cyc & bus__stb;
        if (state_q == IDLE) begin
            eff_adr   = bus__adr;
            eff_we    = bus__we;
            eff_sel   = bus__sel;
            eff_dat_w = bus__dat_w;
        end else begin
            eff_adr   = adr_q;
            eff_we    = we_q;
            eff_sel   = sel_q;
            eff_dat_w = dat_w_q;
        end
        off = eff_adr - BASE_W;
        idx = off[IW-1:0];
`ifdef WB_SRAM_RESPONDER_ERR_EN
        oor = (eff_adr < BASE_W) || (off >= DEPTH_W);
`else
        oor = 1'b0;
`endif
    end

    assign unused_off = ^off;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_w_d = dat_w_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    adr_d   = bus__adr;
                    we_d    = bus__we;
                    sel_d   = bus__sel;
                    dat_w_d = bus__dat_w;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_W;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // RESP is only ever entered from IDLE or WAIT, so this marks the commit edge.
        enter_resp = (state_d == RESP);
        ack_d      = enter_resp && !oor;
        err_d      = enter_resp && oor;
        mem_we     = enter_resp && eff_we && !oor && rst_n;
        dat_r_d    = (enter_resp && !eff_we && !oor) ? mem_q[idx] : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
        end
    end

    always_ff @(posedge clk) begin
        adr_q   <= adr_d;
        we_q    <= we_d;
        sel_q   <= sel_d;
        dat_w_q <= dat_w_d;
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (mem_we && eff_sel[n]) begin
                mem_q[idx][8*n +: 8] <= eff_dat_w[8*n +: 8];
            end
        end
    end

    assign bus__ack   = ack_q;
    assign bus__err   = err_q;
    assign bus__dat_r = dat_r_q;

endmodule
